pipeline_stage_tracker: RTL and testbench
=========================================

Name: pipeline_stage_tracker

Overview:
- Non-intrusive trace monitor for the front and middle of the RISC-V core pipeline (IF, ID, EX).
- Snoops instruction-memory, decode, execute and data-memory handshakes and timestamps each instruction against a free-running cycle counter.
- Emits one completed trace record per instruction leaving EX, for consumption by the downstream write-back tracker.

Parameters:
INSTR_ADDR_WIDTH, 32, instruction address width
INSTR_DATA_WIDTH, 32, instruction word width
FIFO_DEPTH, 8, fetched-but-not-decoded record buffer depth (power of two, >=2)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
if_busy  in  1  IF stage busy (informational, not used for timing)
if_ready  in  1  IF stage ready (informational)
instr_req  in  1  instruction memory request
instr_addr  in  INSTR_ADDR_WIDTH  instruction fetch address
instr_grant  in  1  instruction memory grant
instr_rvalid  in  1  instruction data valid
instr_rdata  in  INSTR_DATA_WIDTH  fetched instruction
id_ready  in  1  ID stage can accept / hand off
jump_done  in  1  jump resolved in ID; prefetched entries invalid
is_decoding  in  1  ID stage actively decoding
illegal_instruction  in  1  instruction in ID is illegal
ex_ready  in  1  EX completes this cycle
data_mem_req  in  1  EX data memory request
data_mem_grant  in  1  data memory grant
data_mem_rvalid  in  1  data memory response valid
wb_previous_end_i  in  32  end timestamp of last WB-retired record
ex_data_ready  out  1  one-cycle pulse: record outputs valid
ex_addr  out  INSTR_ADDR_WIDTH  traced instruction address
ex_instr  out  INSTR_DATA_WIDTH  traced instruction word
if_start, if_end, id_start, id_end, ex_start, ex_end  out  32 each  stage timestamps
mem_access  out  1  instruction performed a data memory access
mem_start, mem_end  out  32 each  data access grant / rvalid timestamps (0 if none)
fifo_overflow  out  1  sticky error flag

Behaviour:
- rst low: counter=0, FIFO empty, ID/EX slots empty, all outputs 0; reset mid-operation discards all in-flight records.
- counter: 32-bit, +1 every clk, wraps modulo 2^32; "now" is the counter value in the sampling cycle.
- IF: instr_req & instr_grant -> latch instr_addr, if_start=now; the next instr_rvalid -> latch instr_rdata, if_end=now, push record to FIFO.
- At most one outstanding fetch is tracked. A grant while one is pending is ignored.
- FIFO full on push -> record dropped, fifo_overflow=1 until reset. Simultaneous push/pop on full is legal (no drop).
- ID: slot empty & FIFO non-empty & is_decoding -> pop head into ID slot, id_start=now.
- ID: slot occupied & id_ready & is_decoding -> id_end=now, move to EX slot (only if EX slot empty or vacating this cycle; otherwise hold).
- illegal_instruction while ID slot occupied -> discard ID record, no output.
- jump_done -> flush all FIFO entries (wrong-path prefetch); ID slot record unaffected; a push in the same cycle is also discarded.
- EX: on entry, ex_start = max(id_end+1, wb_previous_end_i+1), unsigned compare.
- EX: data_mem_req & data_mem_grant -> mem_access=1, mem_start=now. data_mem_rvalid after grant -> mem_end=now.
- EX completes on first cycle with ex_ready and (no access, or rvalid already seen / same cycle): ex_end=now.
- Record registered to outputs; ex_data_ready high exactly one cycle, latency 1 cycle after the completing edge. Outputs hold until next record.
- Back-to-back completions yield back-to-back pulses; ID->EX transfer and EX completion in the same cycle are allowed.

Test Plan:
- Reset release, fetch 0x80 granted cycle 2, rvalid cycle 3 -> FIFO depth 1, if_start=2, if_end=3.
- Single ALU instruction: decode from cycle 4, id_ready cycle 5, ex_ready cycle 6, wb_previous_end_i=0 -> ex_data_ready pulse cycle 7, id_start=4, id_end=5, ex_start=6, ex_end=6, mem_access=0.
- Load: grant cycle 7, rvalid cycle 9, ex_ready cycles 8 and 9 -> ex_end=9, mem_start=7, mem_end=9, mem_access=1.
- Three prefetched entries then jump_done -> FIFO empty; only post-jump fetch appears next; no record from the flushed entries.
- illegal_instruction with ID occupied -> no ex_data_ready for that instruction; following instruction traced normally.
- Nine fetches with no decode -> fifo_overflow=1; the first 8 records are intact; rst low asserted mid-stream clears the flag and all outputs.

Source files
------------

// File: rtl/pipeline_stage_tracker_if.sv
// Handshake bundle between the IF/ID/EX pipeline (master side) and the stage tracker (slave side).
interface pipeline_stage_tracker_if #(
    parameter int unsigned INSTR_ADDR_WIDTH = 32,
    parameter int unsigned INSTR_DATA_WIDTH = 32
);
    logic                        if_busy;
    logic                        if_ready;
    logic                        instr_req;
    logic [INSTR_ADDR_WIDTH-1:0] instr_addr;
    logic                        instr_grant;
    logic                        instr_rvalid;
    logic [INSTR_DATA_WIDTH-1:0] instr_rdata;
    logic                        id_ready;
    logic                        jump_done;
    logic                        is_decoding;
    logic                        illegal_instruction;
    logic                        ex_ready;
    logic                        data_mem_req;
    logic                        data_mem_grant;
    logic                        data_mem_rvalid;
    logic [31:0]                 wb_previous_end_i;

    logic                        ex_data_ready;
    logic [INSTR_ADDR_WIDTH-1:0] ex_addr;
    logic [INSTR_DATA_WIDTH-1:0] ex_instr;
    logic [31:0]                 if_start;
    logic [31:0]                 if_end;
    logic [31:0]                 id_start;
    logic [31:0]                 id_end;
    logic [31:0]                 ex_start;
    logic [31:0]                 ex_end;
    logic                        mem_access;
    logic [31:0]                 mem_start;
    logic [31:0]                 mem_end;
    logic                        fifo_overflow;

    modport master (
        output if_busy, if_ready, instr_req, instr_addr, instr_grant, instr_rvalid, instr_rdata,
               id_ready, jump_done, is_decoding, illegal_instruction, ex_ready, data_mem_req,
               data_mem_grant, data_mem_rvalid, wb_previous_end_i,
        input  ex_data_ready, ex_addr, ex_instr, if_start, if_end, id_start, id_end, ex_start,
               ex_end, mem_access, mem_start, mem_end, fifo_overflow
    );

    modport slave (
        input  if_busy, if_ready, instr_req, instr_addr, instr_grant, instr_rvalid, instr_rdata,
               id_ready, jump_done, is_decoding, illegal_instruction, ex_ready, data_mem_req,
               data_mem_grant, data_mem_rvalid, wb_previous_end_i,
        output ex_data_ready, ex_addr, ex_instr, if_start, if_end, id_start, id_end, ex_start,
               ex_end, mem_access, mem_start, mem_end, fifo_overflow
    );
endinterface

// File: rtl/pipeline_stage_tracker.sv
// Non-intrusive IF/ID/EX trace monitor: timestamps each instruction against a free-running
// cycle counter and emits one completed record per instruction leaving EX.
module pipeline_stage_tracker #(
    parameter int unsigned INSTR_ADDR_WIDTH = 32,
    parameter int unsigned INSTR_DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH       = 8
) (
    input logic                    clk,
    input logic                    rst,
    pipeline_stage_tracker_if.slave bus
);
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;

    typedef struct packed {
        logic [INSTR_ADDR_WIDTH-1:0] addr;
        logic [INSTR_DATA_WIDTH-1:0] instr;
        logic [31:0]                 if_start;
        logic [31:0]                 if_end;
    } fetch_rec_t;

    typedef struct packed {
        fetch_rec_t  f;
        logic [31:0] id_start;
        logic [31:0] id_end;
        logic [31:0] ex_start;
        logic [31:0] ex_end;
        logic        mem_access;
        logic [31:0] mem_start;
        logic [31:0] mem_end;
    } trace_rec_t;

    logic [31:0]                 now_q;
    logic                        fetch_pend_q;
    logic [INSTR_ADDR_WIDTH-1:0] fetch_addr_q;
    logic [31:0]                 fetch_start_q;

    fetch_rec_t                  fifo_mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]             wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]             fifo_cnt_q;

    trace_rec_t                  id_rec_q, ex_rec_q, out_rec_q;
    logic                        id_valid_q, ex_valid_q, ex_rv_q;
    logic                        out_valid_q, overflow_q;

    logic        fetch_take, fetch_done, push_req, push, pop, overflow_set;
    logic        fifo_full, fifo_empty;
    logic        mem_grant_now, mem_rv_now, ex_done, id_drop, id_move;
    logic [31:0] now_p1, wb_p1, ex_start_c;
    fetch_rec_t  push_rec;
    trace_rec_t  id_load_rec, ex_load_rec, ex_done_rec;
    logic        unused_inputs;

    assign unused_inputs = ^{bus.if_busy, bus.if_ready};

    // Only one fetch is tracked; grants arriving while it is pending are ignored.
    assign fetch_take = !fetch_pend_q && bus.instr_req && bus.instr_grant;
    assign fetch_done = fetch_pend_q && bus.instr_rvalid;
    assign push_req   = fetch_done && !bus.jump_done;

    assign fifo_full    = (fifo_cnt_q == CntW'(FIFO_DEPTH));
    assign fifo_empty   = (fifo_cnt_q == '0);
    assign pop          = !id_valid_q && !fifo_empty && bus.is_decoding && !bus.jump_done;
    assign push         = push_req && (!fifo_full || pop);
    assign overflow_set = push_req && fifo_full && !pop;

    assign mem_grant_now = ex_valid_q && !ex_rec_q.mem_access && bus.data_mem_req &&
                           bus.data_mem_grant;
    assign mem_rv_now    = ex_valid_q && ex_rec_q.mem_access && !ex_rv_q && bus.data_mem_rvalid;
    // A grant in this cycle means the access is still outstanding.
    assign ex_done = ex_valid_q && bus.ex_ready &&
                     ((!ex_rec_q.mem_access && !mem_grant_now) || ex_rv_q || mem_rv_now);

    assign id_drop = id_valid_q && bus.illegal_instruction;
    assign id_move = id_valid_q && !bus.illegal_instruction && bus.id_ready && bus.is_decoding &&
                     (!ex_valid_q || ex_done);

    assign now_p1     = now_q + 32'd1;
    assign wb_p1      = bus.wb_previous_end_i + 32'd1;
    assign ex_start_c = (now_p1 > wb_p1) ? now_p1 : wb_p1;

    always_comb begin
        push_rec          = '{addr: fetch_addr_q, instr: bus.instr_rdata,
                              if_start: fetch_start_q, if_end: now_q};
        id_load_rec          = '0;
        id_load_rec.f        = fifo_mem_q[rd_ptr_q];
        id_load_rec.id_start = now_q;
        ex_load_rec          = id_rec_q;
        ex_load_rec.id_end   = now_q;
        ex_load_rec.ex_start = ex_start_c;
        ex_done_rec          = ex_rec_q;
        ex_done_rec.ex_end   = now_q;
        if (mem_rv_now) begin
            ex_done_rec.mem_end = now_q;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= push_rec;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            now_q         <= '0;
            fetch_pend_q  <= 1'b0;
            fetch_addr_q  <= '0;
            fetch_start_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_cnt_q    <= '0;
            id_rec_q      <= '0;
            id_valid_q    <= 1'b0;
            ex_rec_q      <= '0;
            ex_valid_q    <= 1'b0;
            ex_rv_q       <= 1'b0;
            out_rec_q     <= '0;
            out_valid_q   <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            now_q <= now_q + 32'd1;

            if (fetch_take) begin
                fetch_pend_q  <= 1'b1;
                fetch_addr_q  <= bus.instr_addr;
                fetch_start_q <= now_q;
            end else if (fetch_done) begin
                fetch_pend_q <= 1'b0;
            end

            // A jump flushes wrong-path prefetches, including any push in the same cycle.
            if (bus.jump_done) begin
                rd_ptr_q   <= wr_ptr_q;
                fifo_cnt_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
                if (push && !pop) begin
                    fifo_cnt_q <= fifo_cnt_q + CntW'(1);
                end else if (pop && !push) begin
                    fifo_cnt_q <= fifo_cnt_q - CntW'(1);
                end
            end

            if (pop) begin
                id_rec_q   <= id_load_rec;
                id_valid_q <= 1'b1;
            end else if (id_drop || id_move) begin
                id_valid_q <= 1'b0;
            end

            if (id_move) begin
                ex_rec_q   <= ex_load_rec;
                ex_valid_q <= 1'b1;
                ex_rv_q    <= 1'b0;
            end else if (ex_done) begin
                ex_valid_q <= 1'b0;
            end else begin
                if (mem_grant_now) begin
                    ex_rec_q.mem_access <= 1'b1;
                    ex_rec_q.mem_start  <= now_q;
                end
                if (mem_rv_now) begin
                    ex_rv_q          <= 1'b1;
                    ex_rec_q.mem_end <= now_q;
                end
            end

            out_valid_q <= ex_done;
            if (ex_done) begin
                out_rec_q <= ex_done_rec;
            end
            if (overflow_set) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign bus.ex_data_ready = out_valid_q;
    assign bus.ex_addr       = out_rec_q.f.addr;
    assign bus.ex_instr      = out_rec_q.f.instr;
    assign bus.if_start      = out_rec_q.f.if_start;
    assign bus.if_end        = out_rec_q.f.if_end;
    assign bus.id_start      = out_rec_q.id_start;
    assign bus.id_end        = out_rec_q.id_end;
    assign bus.ex_start      = out_rec_q.ex_start;
    assign bus.ex_end        = out_rec_q.ex_end;
    assign bus.mem_access    = out_rec_q.mem_access;
    assign bus.mem_start     = out_rec_q.mem_start;
    assign bus.mem_end       = out_rec_q.mem_end;
    assign bus.fifo_overflow = overflow_q;
endmodule

// File: tb/tb_pipeline_stage_tracker.sv
// Directed scenarios plus randomized traffic checked cycle by cycle against a queue-based model.
module tb_pipeline_stage_tracker;
    localparam int unsigned Depth = 8;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] if_start;
        logic [31:0] if_end;
        logic [31:0] id_start;
        logic [31:0] id_end;
        logic [31:0] ex_start;
        logic [31:0] ex_end;
        logic        mem_access;
        logic [31:0] mem_start;
        logic [31:0] mem_end;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    pipeline_stage_tracker_if #(.INSTR_ADDR_WIDTH(32), .INSTR_DATA_WIDTH(32)) bus_if ();

    pipeline_stage_tracker #(
        .INSTR_ADDR_WIDTH(32),
        .INSTR_DATA_WIDTH(32),
        .FIFO_DEPTH      (Depth)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    // Reference model state
    logic [31:0] m_cnt;
    rec_t        m_fifo[$];
    rec_t        m_id, m_ex, m_out;
    logic        m_id_v, m_ex_v, m_rv, m_pend, m_rdy, m_ovf;
    logic [31:0] m_fa, m_fs;

    task automatic model_reset();
        m_cnt = 0; m_fifo.delete(); m_id = '0; m_ex = '0; m_out = '0;
        m_id_v = 0; m_ex_v = 0; m_rv = 0; m_pend = 0; m_rdy = 0; m_ovf = 0; m_fa = 0; m_fs = 0;
    endtask

    task automatic model_step();
        logic [31:0] now, a, b;
        logic        gnow, done, id_pre;
        rec_t        r;
        now = m_cnt; gnow = 0; done = 0; id_pre = m_id_v;
        if (m_ex_v) begin
            if (!m_ex.mem_access && bus_if.data_mem_req && bus_if.data_mem_grant) begin
                m_ex.mem_access = 1; m_ex.mem_start = now; gnow = 1;
            end else if (m_ex.mem_access && !m_rv && bus_if.data_mem_rvalid) begin
                m_rv = 1; m_ex.mem_end = now;
            end
            done = bus_if.ex_ready && !gnow && (!m_ex.mem_access || m_rv);
        end
        m_rdy = done;
        if (done) begin
            m_out = m_ex; m_out.ex_end = now; m_ex_v = 0;
        end
        if (m_id_v) begin
            if (bus_if.illegal_instruction) m_id_v = 0;
            else if (bus_if.id_ready && bus_if.is_decoding && !m_ex_v) begin
                m_ex = m_id; m_ex.id_end = now;
                a = now + 1; b = bus_if.wb_previous_end_i + 1;
                m_ex.ex_start = (a > b) ? a : b;
                m_ex_v = 1; m_rv = 0; m_id_v = 0;
            end
        end
        if (!id_pre && m_fifo.size() > 0 && bus_if.is_decoding && !bus_if.jump_done) begin
            m_id = m_fifo.pop_front(); m_id.id_start = now; m_id_v = 1;
        end
        if (m_pend && bus_if.instr_rvalid) begin
            m_pend = 0;
            if (!bus_if.jump_done) begin
                if (m_fifo.size() < Depth) begin
                    r = '0; r.addr = m_fa; r.instr = bus_if.instr_rdata;
                    r.if_start = m_fs; r.if_end = now;
                    m_fifo.push_back(r);
                end else m_ovf = 1;
            end
        end else if (!m_pend && bus_if.instr_req && bus_if.instr_grant) begin
            m_pend = 1; m_fa = bus_if.instr_addr; m_fs = now;
        end
        if (bus_if.jump_done) m_fifo.delete();
        m_cnt = m_cnt + 1;
    endtask

    function automatic rec_t dut_rec();
        return '{addr: bus_if.ex_addr, instr: bus_if.ex_instr, if_start: bus_if.if_start,
                 if_end: bus_if.if_end, id_start: bus_if.id_start, id_end: bus_if.id_end,
                 ex_start: bus_if.ex_start, ex_end: bus_if.ex_end,
                 mem_access: bus_if.mem_access, mem_start: bus_if.mem_start,
                 mem_end: bus_if.mem_end};
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("ex_data_ready", 512'(bus_if.ex_data_ready), 512'(m_rdy));
        chk("fifo_overflow", 512'(bus_if.fifo_overflow), 512'(m_ovf));
        chk("record", 512'(dut_rec()), 512'(m_out));
    endtask

    task automatic idle();
        bus_if.if_busy = 0; bus_if.if_ready = 1; bus_if.instr_req = 0; bus_if.instr_grant = 0;
        bus_if.instr_rvalid = 0; bus_if.id_ready = 0; bus_if.jump_done = 0;
        bus_if.is_decoding = 0; bus_if.illegal_instruction = 0; bus_if.ex_ready = 0;
        bus_if.data_mem_req = 0; bus_if.data_mem_grant = 0; bus_if.data_mem_rvalid = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [31:0] data);
        bus_if.instr_req = 1; bus_if.instr_grant = 1; bus_if.instr_addr = addr;
        tick(); idle();
        bus_if.instr_rvalid = 1; bus_if.instr_rdata = data;
        tick(); idle();
    endtask

    task automatic decode_exec();
        bus_if.is_decoding = 1;
        tick();
        bus_if.id_ready = 1;
        tick(); idle();
        bus_if.ex_ready = 1;
        tick(); idle();
    endtask

    task automatic hard_reset();
        rst = 0;
        #1;
        model_reset();
        chk("reset_ready", 512'(bus_if.ex_data_ready), 512'(0));
        chk("reset_ovf", 512'(bus_if.fifo_overflow), 512'(0));
        chk("reset_record", 512'(dut_rec()), 512'(0));
        @(negedge clk); @(negedge clk);
        rst = 1;
    endtask

    initial begin
        idle();
        bus_if.instr_addr = 0; bus_if.instr_rdata = 0; bus_if.wb_previous_end_i = 0;
        @(negedge clk);
        hard_reset();

        // ALU instruction: fetch at 2/3, decode 4/5, execute 6, pulse in cycle 7
        tick(); tick();
        fetch(32'h80, 32'h0000_0013);
        decode_exec();
        chk("alu_ready", 512'(bus_if.ex_data_ready), 512'(1));
        chk("alu_times", 512'({bus_if.if_start, bus_if.if_end, bus_if.id_start, bus_if.id_end,
                               bus_if.ex_start, bus_if.ex_end}),
            512'({32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd6}));
        chk("alu_mem", 512'(bus_if.mem_access), 512'(0));
        tick();
        chk("alu_pulse_one_cycle", 512'(bus_if.ex_data_ready), 512'(0));

        // Load with WB-late start: fetch 8/9, decode 10/11, grant 12, rvalid 14
        fetch(32'h84, 32'h0000_2083);
        bus_if.is_decoding = 1; tick();
        bus_if.id_ready = 1; bus_if.wb_previous_end_i = 32'd20; tick(); idle();
        bus_if.wb_previous_end_i = 0;
        bus_if.data_mem_req = 1; bus_if.data_mem_grant = 1; bus_if.ex_ready = 1; tick(); idle();
        bus_if.ex_ready = 1; tick(); idle();
        bus_if.ex_ready = 1; bus_if.data_mem_rvalid = 1; tick(); idle();
        chk("load_ready", 512'(bus_if.ex_data_ready), 512'(1));
        chk("load_fields", 512'({bus_if.ex_addr, bus_if.mem_access, bus_if.mem_start,
                                 bus_if.mem_end, bus_if.ex_start, bus_if.ex_end}),
            512'({32'h84, 1'b1, 32'd12, 32'd14, 32'd21, 32'd14}));

        // Jump flushes three prefetches and a same-cycle push
        fetch(32'h100, 32'h1); fetch(32'h104, 32'h2); fetch(32'h108, 32'h3);
        bus_if.instr_req = 1; bus_if.instr_grant = 1; bus_if.instr_addr = 32'h10c; tick(); idle();
        bus_if.instr_rvalid = 1; bus_if.instr_rdata = 32'h4; bus_if.jump_done = 1; tick(); idle();
        fetch(32'h200, 32'h5);
        decode_exec();
        chk("jump_target", 512'({bus_if.ex_data_ready, bus_if.ex_addr}), 512'({1'b1, 32'h200}));

        // Illegal instruction discarded in ID; successor traced
        fetch(32'h300, 32'h6); fetch(32'h304, 32'h7);
        bus_if.is_decoding = 1; tick(); idle();
        bus_if.illegal_instruction = 1; tick(); idle();
        decode_exec();
        chk("illegal_next", 512'({bus_if.ex_data_ready, bus_if.ex_addr}), 512'({1'b1, 32'h304}));

        // Nine fetches without decode overflow an 8-deep buffer
        for (int i = 0; i < 9; i++) fetch(32'h400 + 32'(4 * i), 32'(i));
        chk("overflow_flag", 512'(bus_if.fifo_overflow), 512'(1));
        decode_exec();
        chk("overflow_head", 512'(bus_if.ex_addr), 512'(32'h400));
        decode_exec(); decode_exec();
        chk("overflow_third", 512'(bus_if.ex_addr), 512'(32'h408));
        @(negedge clk);
        hard_reset();

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            bus_if.instr_req = 1'($urandom_range(0, 1));
            bus_if.instr_grant = 1'($urandom_range(0, 1));
            bus_if.instr_addr = $urandom;
            bus_if.instr_rvalid = ($urandom_range(0, 2) != 0);
            bus_if.instr_rdata = $urandom;
            bus_if.jump_done = ($urandom_range(0, 19) == 0);
            bus_if.is_decoding = ($urandom_range(0, 3) != 0);
            bus_if.id_ready = 1'($urandom_range(0, 1));
            bus_if.illegal_instruction = ($urandom_range(0, 24) == 0);
            bus_if.ex_ready = 1'($urandom_range(0, 1));
            bus_if.data_mem_req = ($urandom_range(0, 3) == 0);
            bus_if.data_mem_grant = 1'($urandom_range(0, 1));
            bus_if.data_mem_rvalid = ($urandom_range(0, 2) == 0);
            bus_if.wb_previous_end_i = (m_cnt > 10) ? m_cnt + $urandom_range(0, 6) - 3 : 0;
            tick();
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
